// File: rtl/vertical_window_gen_fp16_if.sv
// Pixel-stream in / vertical-window out bundle for vertical_window_gen_fp16.
// The slave side is the window generator; the master side is whatever
// produces the raster pixels and consumes the windows.
//
// Handshake: valid_i qualifies data_i/col_i/row_i for exactly one cycle and
// there is no ready (no backpressure); valid_o qualifies window_o/col_o/row_o
// for one cycle, and those outputs hold their last values while valid_o=0.
interface vertical_window_gen_fp16_if #(
    parameter int FP_WIDTH_REG  = 16,
    parameter int WINDOW_HEIGHT = 3
);
    logic [FP_WIDTH_REG-1:0] data_i;
    logic [15:0]             col_i;
    logic [15:0]             row_i;
    logic                    valid_i;
    logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][1];
    logic [15:0]             col_o;
    logic [15:0]             row_o;
    logic                    valid_o;
    logic                    overflow_o;

    modport master (
        output data_i, col_i, row_i, valid_i,
        input  window_o, col_o, row_o, valid_o, overflow_o
    );

    modport slave (
        input  data_i, col_i, row_i, valid_i,
        output window_o, col_o, row_o, valid_o, overflow_o
    );
endinterface

// File: rtl/vertical_window_gen_fp16.sv
// Line-buffer based generator of WINDOW_HEIGHT x 1 vertical fp16 windows from
// a raster pixel stream. Rows outside the image read as zero; after the last
// pixel of a frame the block injects HALF virtual zero rows to drain the
// bottom windows. fsm_state_o exposes the controller state for debug.
module vertical_window_gen_fp16 #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int WINDOW_HEIGHT = 3,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    vertical_window_gen_fp16_if.slave   win_if,
    output logic [1:0]                  fsm_state_o
);
    localparam int          HALF     = (WINDOW_HEIGHT - 1) / 2;
    localparam int          NLB      = WINDOW_HEIGHT - 1;
    localparam int          CW       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [15:0] HALF16   = 16'(HALF);
    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] LAST_F   = 16'(HALF - 1);
    localparam logic [15:0] IMG_H16  = 16'(IMAGE_HEIGHT);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        STREAM   = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             fc_q, fc_d;
    logic [15:0]             f_q, f_d;
    logic                    overflow_q, overflow_d;
    logic [FP_WIDTH_REG-1:0] window_q [WINDOW_HEIGHT][1];
    logic [FP_WIDTH_REG-1:0] window_d [WINDOW_HEIGHT][1];
    logic [15:0]             col_q, col_d;
    logic [15:0]             row_q, row_d;
    logic                    valid_q, valid_d;

    // lb_mem[j][c] holds row r-1-j for the pixel currently at column c.
    logic [FP_WIDTH_REG-1:0] lb_mem [NLB][IMAGE_WIDTH];

    // The pixel being processed this cycle: real input or flush injection.
    logic                    proc_en;
    logic [FP_WIDTH_REG-1:0] proc_data;
    logic [15:0]             proc_col;
    logic [15:0]             proc_row;
    logic [CW-1:0]           proc_addr;
    logic                    is_last;

    assign proc_addr = proc_col[CW-1:0];
    assign is_last   = (win_if.col_i == LAST_COL) && (win_if.row_i == LAST_ROW);

    // True when window tap k of a pixel on row 'row' sources a row inside the image.
    function automatic logic src_ok(input logic [15:0] row, input int k);
        int src;
        src = int'(row) - 2 * HALF + k;
        return (src >= 0) && (src <= IMAGE_HEIGHT - 1);
    endfunction

    // Controller: frame tracking, flush injection and sticky overflow.
    always_comb begin
        state_d    = state_q;
        fc_d       = fc_q;
        f_d        = f_q;
        overflow_d = overflow_q;
        proc_en    = 1'b0;
        proc_data  = win_if.data_i;
        proc_col   = win_if.col_i;
        proc_row   = win_if.row_i;
        case (state_q)
            WAIT_SOF: begin
                if (win_if.valid_i && (win_if.col_i == 16'd0) && (win_if.row_i == 16'd0)) begin
                    proc_en = 1'b1;
                    state_d = is_last ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (win_if.valid_i) begin
                    proc_en = 1'b1;
                    if (is_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                proc_en    = 1'b1;
                proc_data  = '0;
                proc_col   = fc_q;
                proc_row   = IMG_H16 + f_q;
                overflow_d = overflow_q | win_if.valid_i;
                if (fc_q == LAST_COL) begin
                    fc_d = 16'd0;
                    if (f_q == LAST_F) begin
                        f_d     = 16'd0;
                        state_d = WAIT_SOF;
                    end else begin
                        f_d = f_q + 16'd1;
                    end
                end else begin
                    fc_d = fc_q + 16'd1;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    // Window assembly; rows 0..HALF-1 only fill the buffers.
    always_comb begin
        window_d = window_q;
        col_d    = col_q;
        row_d    = row_q;
        valid_d  = 1'b0;
        if (proc_en && (proc_row >= HALF16)) begin
            valid_d = 1'b1;
            col_d   = proc_col;
            row_d   = proc_row - HALF16;
            for (int k = 0; k < WINDOW_HEIGHT - 1; k++) begin
                window_d[k][0] = src_ok(proc_row, k) ? lb_mem[NLB-1-k][proc_addr] : '0;
            end
            window_d[WINDOW_HEIGHT-1][0] = src_ok(proc_row, WINDOW_HEIGHT - 1) ? proc_data : '0;
        end
    end

    // Line buffers shift down one row at the processed column (read-before-write).
    always_ff @(posedge clk_i) begin
        if (proc_en) begin
            lb_mem[0][proc_addr] <= proc_data;
            for (int j = 1; j < NLB; j++) begin
                lb_mem[j][proc_addr] <= lb_mem[j-1][proc_addr];
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= WAIT_SOF;
            fc_q       <= 16'd0;
            f_q        <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fc_q       <= fc_d;
            f_q        <= f_d;
            overflow_q <= overflow_d;
        end
    end

    // Registered window outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < WINDOW_HEIGHT; k++) window_q[k][0] <= '0;
            col_q   <= 16'd0;
            row_q   <= 16'd0;
            valid_q <= 1'b0;
        end else begin
            window_q <= window_d;
            col_q    <= col_d;
            row_q    <= row_d;
            valid_q  <= valid_d;
        end
    end

    assign win_if.window_o   = window_q;
    assign win_if.col_o      = col_q;
    assign win_if.row_o      = row_q;
    assign win_if.valid_o    = valid_q;
    assign win_if.overflow_o = overflow_q;
    assign fsm_state_o       = state_q;
endmodule

// File: doc/vertical_window_gen_fp16.md
# vertical_window_gen_fp16

- Streaming line-buffer block that turns a raster-order stream of fp16 pixels into WINDOW_HEIGHT x 1 vertical windows.
- Its output ports plug directly into the `window_i`/`col_i`/`row_i`/`valid_i` inputs of the vertical box-filter convolution wrappers, so it is the producer end of that interface.
- Missing rows above and below the image are zero-padded.
- At end of frame it drains the bottom rows itself by injecting virtual zero rows.

## Interface
- EXP_WIDTH, 5: fp exponent bits.
- FRAC_WIDTH, 10: fp fraction bits.
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH: pixel width.
- WINDOW_HEIGHT, 3: window rows; odd, ≥3. HALF = (WINDOW_HEIGHT-1)/2.
- IMAGE_WIDTH, 640: pixels per line; line-buffer depth.
- IMAGE_HEIGHT, 480: lines per frame.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, asynchronous, active-low.
- data_i  in  FP_WIDTH_REG  pixel, raster order.
- col_i  in  16  pixel column.
- row_i  in  16  pixel row.
- valid_i  in  1  pixel qualifier; no backpressure.
- window_o  out  FP_WIDTH_REG [WINDOW_HEIGHT][1]  vertical window; index 0 = top row.
- col_o  out  16  center column.
- row_o  out  16  center row.
- valid_o  out  1  window qualifier.
- overflow_o  out  1  sticky; input arrived during FLUSH.

## Operation
- Storage: WINDOW_HEIGHT-1 line buffers lb[0..H-2], each IMAGE_WIDTH x FP_WIDTH_REG, addressed by column.
  - lb[j][c] holds row r-1-j.
  - Read-before-write on every accepted pixel at column c: lb[0][c] <= data_i, lb[j][c] <= lb[j-1][c].
- Window assembly for input (c, r):
  - window[H-1] = data_i; window[H-2-j] = lb[j][c].
  - center = r-HALF; source row of window[k] = center-HALF+k.
  - Entry k is forced to 16'h0000 if its source row is <0 or >IMAGE_HEIGHT-1.
  - Stale buffer contents from a previous frame or from before reset are therefore never visible.
- Output emitted only when center ≥ 0; rows 0..HALF-1 of the input only fill buffers.
- col_o = c; row_o = center.
- FSM:
  - WAIT_SOF (reset state): ignore input until valid_i with col_i==0, row_i==0. That pixel is accepted in the same cycle, then go to STREAM.
  - STREAM: accept every valid_i pixel. Accepting (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) moves to FLUSH next cycle.
  - FLUSH: each cycle, inject a virtual pixel with data 0, row IMAGE_HEIGHT+f, col fc, processed exactly as a real pixel.
    - fc counts 0..IMAGE_WIDTH-1; f counts 0..HALF-1.
    - After HALF*IMAGE_WIDTH cycles, go to WAIT_SOF.
- valid_i during FLUSH: pixel dropped and overflow_o set. overflow_o stays set until reset. Flush output is unaffected.
- Upstream contract: at least HALF*IMAGE_WIDTH idle cycles between the last pixel of a frame and the next SOF.

## Timing
- All outputs registered; latency is exactly 1 cycle from the accepted (or virtual) pixel to its window.
- Throughput: 1 pixel/cycle; valid_i gaps propagate as valid_o gaps.
- Back-to-back frame: the last real output is at t+1 (t = cycle the last pixel is accepted). Flush outputs follow at t+2..t+1+HALF*IMAGE_WIDTH with no gap.
- Async reset (rst_i low) forces:
  - window_o=0, col_o=0, row_o=0, valid_o=0, overflow_o=0;
  - FSM=WAIT_SOF; flush counters cleared.
- Line buffers are not reset.
- Reset deassertion mid-frame: no valid_o until the next SOF pixel.
- Outputs hold their last values while valid_o=0.

## Test plan
- 4x3 frame (IMAGE_WIDTH=4, IMAGE_HEIGHT=3, H=3), valid_i continuous cycles 0-11, row r = 3C00/4000/4200 (1.0/2.0/3.0):
  - valid_o high cycles 5-16, 12 windows;
  - row_o 0 window {0000,3C00,4000}; row_o 1 window {3C00,4000,4200}; row_o 2 window {4000,4200,0000};
  - col_o cycles 0-3 within each row.
- Same frame with valid_i toggled every other cycle: identical window sequence; each valid_o exactly 1 cycle after its driving pixel; flush remains contiguous.
- valid_i asserted on cycle 13 during FLUSH: overflow_o=1 from cycle 14 onward; flush windows unchanged; the pixel produces no output.
- rst_i low for 2 cycles mid row 1:
  - all outputs 0 immediately (asynchronous);
  - remaining pixels of that frame produce no valid_o;
  - next frame starting at (0,0) produces the full correct 12 windows.
- Two frames separated by exactly 4 idle cycles, second frame all 4400 (4.0): frame-2 row_o 0 window {0000,4400,4400}, with no frame-1 data visible.
- WINDOW_HEIGHT=5, 4x5 frame, row r = fp16(r+1):
  - row_o 0 window {0,0,3C00,4000,4200};
  - row_o 4 window {4200,4400,4500,0,0};
  - flush lasts 8 cycles.
